// File: rtl/div_iter.sv
// Iterative 32-bit integer divider: one restoring radix-2 step per clock,
// signed/unsigned quotient or remainder with fixed 34-cycle START-to-DONE latency.
module div_iter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SIGN,
    input  logic        REM,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] div_reg;
    logic [31:0] rs1_reg;
    logic [31:0] result_reg;
    logic        sign_reg;
    logic        rem_sel_reg;
    logic        neg2_reg;

    logic [31:0] abs1, abs2;
    logic [32:0] rem_shift;
    logic [31:0] rem_sub;
    logic        step_ok;
    logic        neg1;
    logic [31:0] q_out, r_out, fix_result;

    assign abs1 = (SIGN && RS1[31]) ? (32'd0 - RS1) : RS1;
    assign abs2 = (SIGN && RS2[31]) ? (32'd0 - RS2) : RS2;

    // The 32-bit subtraction is exact whenever the step succeeds, because the
    // new partial remainder is always below a nonzero divisor.
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign step_ok   = (rem_shift >= {1'b0, div_reg});
    assign rem_sub   = rem_shift[31:0] - div_reg;

    assign neg1 = sign_reg & rs1_reg[31];

    always_comb begin
        q_out = (sign_reg && (neg1 ^ neg2_reg)) ? (32'd0 - quo_reg) : quo_reg;
        r_out = neg1 ? (32'd0 - rem_reg) : rem_reg;
        if (div_reg == 32'd0) begin
            q_out = 32'hFFFF_FFFF;
            r_out = rs1_reg;
        end
        fix_result = rem_sel_reg ? r_out : q_out;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (START) state_next = S_CALC;
            S_CALC:  if (count_reg == 5'd31) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg   <= 5'd0;
            rem_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            div_reg     <= 32'd0;
            rs1_reg     <= 32'd0;
            result_reg  <= 32'd0;
            sign_reg    <= 1'b0;
            rem_sel_reg <= 1'b0;
            neg2_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        count_reg   <= 5'd0;
                        rem_reg     <= 32'd0;
                        quo_reg     <= abs1;
                        div_reg     <= abs2;
                        rs1_reg     <= RS1;
                        sign_reg    <= SIGN;
                        rem_sel_reg <= REM;
                        neg2_reg    <= SIGN & RS2[31];
                    end
                end
                S_CALC: begin
                    rem_reg   <= step_ok ? rem_sub : rem_shift[31:0];
                    quo_reg   <= {quo_reg[30:0], step_ok};
                    count_reg <= count_reg + 5'd1;
                end
                S_FIX: begin
                    result_reg <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign BUSY   = (state_reg != S_IDLE);
    assign DONE   = (state_reg == S_DONE);
    assign RESULT = result_reg;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: arithmetic reference model plus a per-cycle checker of
// BUSY, DONE and RESULT, driven by directed vectors with hand-computed answers.
module tb_div_iter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        SIGN;
    logic        REM;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    div_iter dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SIGN   (SIGN),
        .REM    (REM),
        .RS1    (RS1),
        .RS2    (RS2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          s;
        logic [31:0] res;
    } rec_t;

    typedef struct {
        bit          s;
        bit          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hand;
    } vec_t;

    rec_t        exp_q[$];
    vec_t        vecs[$];
    logic [31:0] last_result = 32'd0;
    bit          checking = 1'b0;
    int          tests = 0;
    int          fails = 0;

    // Reference: plain integer division, truncating toward zero.
    function automatic logic [31:0] model(bit s, bit r, logic [31:0] a, logic [31:0] b);
        longint      sa, sb, lq, lr;
        logic [63:0] tq, tr;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (!s) return r ? (a % b) : (a / b);
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        lq = sa / sb;
        lr = sa % sb;
        tq = lq;
        tr = lr;
        return r ? tr[31:0] : tq[31:0];
    endfunction

    // Per-cycle checker: an accepted START at cycle c means BUSY over
    // cycles c+1..c+34 and a DONE pulse with the answer at c+34.
    always @(negedge CLK) begin
        if (checking && !RST) begin
            bit          exp_busy;
            bit          exp_done;
            logic [31:0] exp_val;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_val  = last_result;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (cyc >= exp_q[i].s + 1 && cyc <= exp_q[i].s + 34) exp_busy = 1'b1;
                if (cyc == exp_q[i].s + 34) begin
                    exp_done = 1'b1;
                    exp_val  = exp_q[i].res;
                end
            end
            tests++;
            if (BUSY !== exp_busy) begin
                fails++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BUSY, exp_busy);
            end
            tests++;
            if (DONE !== exp_done) begin
                fails++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, DONE, exp_done);
            end
            if (exp_done || !exp_busy) begin
                tests++;
                if (RESULT !== exp_val) begin
                    fails++;
                    $display("FAIL result cyc=%0d got=%h exp=%h", cyc, RESULT, exp_val);
                end
            end
            if (exp_done) begin
                $display("[TB] op done cyc=%0d result=%h expected=%h", cyc, RESULT, exp_val);
                last_result = exp_val;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Called just after a rising edge; START is sampled on the next edge.
    task automatic issue(bit s, bit r, logic [31:0] a, logic [31:0] b, logic [31:0] hand);
        rec_t        rec;
        logic [31:0] m;
        m = model(s, r, a, b);
        tests++;
        if (m !== hand) begin
            fails++;
            $display("FAIL model s=%0d r=%0d a=%h b=%h got=%h exp=%h", s, r, a, b, m, hand);
        end
        rec.s   = cyc;
        rec.res = hand;
        exp_q.push_back(rec);
        START = 1'b1;
        SIGN  = s;
        REM   = r;
        RS1   = a;
        RS2   = b;
        idle(1);
        // Scramble operands while busy; the captured values must be used.
        START = 1'b0;
        SIGN  = 1'($urandom);
        REM   = 1'($urandom);
        RS1   = $urandom;
        RS2   = $urandom;
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        SIGN  = 1'b0;
        REM   = 1'b0;
        RS1   = 32'd0;
        RS2   = 32'd0;

        vecs.push_back('{1'b0, 1'b0, 32'd100,       32'd7,         32'd14});
        vecs.push_back('{1'b0, 1'b1, 32'd100,       32'd7,         32'd2});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{1'b0, 1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678});
        vecs.push_back('{1'b1, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678});
        vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF});
        vecs.push_back('{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
        vecs.push_back('{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1});
        vecs.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_BEEF});

        // START held high during reset must not launch an operation.
        idle(1);
        START = 1'b1;
        idle(2);
        RST      = 1'b0;
        START    = 1'b0;
        checking = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].hand);
            idle(36);
        end

        // START with other operands while busy is ignored; a START in the
        // IDLE cycle right after DONE is accepted.
        issue(1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        idle(4);
        START = 1'b1;
        SIGN  = 1'b1;
        REM   = 1'b1;
        RS1   = 32'h8000_0000;
        RS2   = 32'd3;
        idle(1);
        START = 1'b0;
        idle(29);
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        idle(36);

        // Reset on the tenth CALC cycle aborts without a DONE pulse.
        issue(1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
        idle(9);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        exp_q.delete();
        last_result = 32'd0;
        idle(40);
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        idle(36);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending got=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
